// File: rtl/fetch_queue.sv
// In-order {pc, instr} FIFO between IF and ID with fetch back-pressure and redirect flush.
// Optional same-cycle empty-queue forwarding when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
  parameter  int WORD_SIZE = 32,
  parameter  int ADDR_SIZE = 10,
  parameter  int DEPTH     = 4,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ADDR_SIZE-1:0] in_pc,
  input  logic [WORD_SIZE-1:0] in_instr,
  output logic                 fetch_en,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_SIZE-1:0] out_pc,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic [PTR_W:0]       count,
  output logic                 ovf
);

  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);

  logic [ADDR_SIZE-1:0] pc_mem_r    [DEPTH];
  logic [WORD_SIZE-1:0] instr_mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W:0]       count_r;
  logic                 ovf_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic bypass_s;

  // Handshake decode and head selection; full/empty come only from the registered count.
  always_comb begin
    full_s   = (count_r == CNT_DEPTH);
    empty_s  = (count_r == {(PTR_W+1){1'b0}});
    pop_s    = !empty_s && out_ready && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s = empty_s && in_valid && !flush;
`else
    bypass_s = 1'b0;
`endif
    // A forwarded pair that ID accepts immediately is never written.
    push_s   = in_valid && !full_s && !flush && !(bypass_s && out_ready);
    fetch_en = !full_s;
    if (bypass_s) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end else begin
      out_valid = !empty_s;
      out_pc    = pc_mem_r[rd_ptr_r];
      out_instr = instr_mem_r[rd_ptr_r];
    end
  end

  // Storage, pointers, occupancy and sticky overflow; flush outranks push/pop, rst outranks flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      ovf_r    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= {ADDR_SIZE{1'b0}};
        instr_mem_r[i] <= {WORD_SIZE{1'b0}};
      end
    end else if (flush) begin
      count_r  <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= wr_ptr_r;
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= in_pc;
        instr_mem_r[wr_ptr_r] <= in_instr;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (in_valid && full_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign count = count_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [9:0]  in_pc, out_pc;
  logic [31:0] in_instr, out_instr;
  logic        fetch_en, out_valid, ovf;
  logic [2:0]  count;

  logic [41:0] mdl_q [$];
  logic        mdl_ovf;
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_queue #(.WORD_SIZE(32), .ADDR_SIZE(10), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .fetch_en(fetch_en), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic r, input logic iv, input logic [9:0] pc,
                       input logic [31:0] ins, input logic fl, input logic rdy);
    rst = r; in_valid = iv; in_pc = pc; in_instr = ins; flush = fl; out_ready = rdy;
    #1;
  endtask

  // Advance one clock and apply the behavioural FIFO rules to the model.
  task automatic tick();
    bit full, empty, consumed, do_pop, do_push;
    full     = (mdl_q.size() == DEPTH);
    empty    = (mdl_q.size() == 0);
    consumed = BYP && empty && in_valid && out_ready;
    do_pop   = !empty && out_ready;
    do_push  = in_valid && !full && !consumed;
    @(posedge clk);
    if (rst) begin
      mdl_q.delete();
      mdl_ovf = 1'b0;
    end else if (flush) begin
      mdl_q.delete();
    end else begin
      if (in_valid && full) mdl_ovf = 1'b1;
      if (do_pop) void'(mdl_q.pop_front());
      if (do_push) mdl_q.push_back({in_pc, in_instr});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    apply(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 10'h3FF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    tick();
    tick();
    apply(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (fetch_en !== 1'b1) begin n_err++; $display("FAIL reset_fetch_en got %b want 1", fetch_en); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_cmp++; if (out_pc !== 10'h000) begin n_err++; $display("FAIL reset_out_pc got %h want 000", out_pc); end
    n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 10'(i * 4), 32'h13 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    apply(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", count); end
    n_cmp++; if (fetch_en !== 1'b0) begin n_err++; $display("FAIL fill_fetch_en got %b want 0", fetch_en); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fill_ovf_early got %b want 0", ovf); end
    apply(1'b0, 1'b1, 10'h010, 32'h23, 1'b0, 1'b0);
    tick();
    apply(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL fill_ovf got %b want 1", ovf); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count_after_drop got %0d want 4", count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 10'(i * 4) || out_instr !== 32'h13 + 32'(i * 4)) begin
        n_err++;
        $display("FAIL drain_%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, 10'(i * 4), 32'h13 + 32'(i * 4));
      end
      tick();
    end
    apply(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", count); end
    n_cmp++; if (fetch_en !== 1'b1) begin n_err++; $display("FAIL drain_fetch_en got %b want 1", fetch_en); end
  endtask

  task automatic test_wrap();
    logic [9:0] next_in, next_out;
    next_in  = 10'h040;
    next_out = 10'h040;
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b1, next_in, {22'h0, next_in} ^ 32'hA5A5_0000, 1'b0, 1'b0);
      tick();
      next_in = next_in + 10'd4;
    end
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, next_in, {22'h0, next_in} ^ 32'hA5A5_0000, 1'b0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== next_out || out_instr !== ({22'h0, next_out} ^ 32'hA5A5_0000)) begin
        n_err++;
        $display("FAIL wrap_%0d got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, next_out);
      end
      n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL wrap_count_%0d got %0d want 2", i, count); end
      tick();
      next_in  = next_in + 10'd4;
      next_out = next_out + 10'd4;
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 10'h080 + 10'(i), 32'h77 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    apply(1'b0, 1'b1, 10'h0F0, 32'hDEAD, 1'b1, 1'b1);
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got %0d want 3", count); end
    tick();
    apply(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (fetch_en !== 1'b1) begin n_err++; $display("FAIL flush_fetch_en got %b want 1", fetch_en); end
    apply(1'b0, 1'b1, 10'h100, 32'h0000_0100, 1'b0, 1'b0);
    tick();
    apply(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 10'h100 || out_instr !== 32'h0000_0100) begin
      n_err++;
      $display("FAIL flush_first_out got v=%b pc=%h instr=%h want v=1 pc=100 instr=00000100", out_valid, out_pc, out_instr);
    end
    tick();
  endtask

  task automatic test_bypass();
    apply(1'b0, 1'b1, 10'h020, 32'h0000_0033, 1'b0, 1'b1);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL bypass_pre_count got %0d want 0", count); end
    if (BYP) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 10'h020 || out_instr !== 32'h33) begin
        n_err++;
        $display("FAIL bypass_same_cycle got v=%b pc=%h want v=1 pc=020", out_valid, out_pc);
      end
      tick();
      apply(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0);
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL bypass_count got %0d want 0", count); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bypass_after_valid got %b want 0", out_valid); end
    end else begin
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nobypass_same_cycle got %b want 0", out_valid); end
      tick();
      apply(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 10'h020) begin
        n_err++;
        $display("FAIL nobypass_next_cycle got v=%b pc=%h want v=1 pc=020", out_valid, out_pc);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        r, iv, fl, rdy, exp_v, byp;
    logic [9:0]  pc;
    logic [31:0] ins;
    logic [41:0] exp_pair;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      iv  = ($urandom_range(0, 99) < 65);
      fl  = ($urandom_range(0, 99) < 5);
      rdy = ($urandom_range(0, 99) < 45);
      pc  = 10'($urandom);
      ins = $urandom;
      apply(r, iv, pc, ins, fl, rdy);
      byp      = BYP && (mdl_q.size() == 0) && iv && !fl;
      exp_v    = (mdl_q.size() != 0) || byp;
      exp_pair = byp ? {pc, ins} : ((mdl_q.size() != 0) ? mdl_q[0] : 42'h0);
      n_cmp++; if (out_valid !== exp_v) begin n_err++; $display("FAIL rand_valid_%0d got %b want %b", i, out_valid, exp_v); end
      if (exp_v) begin
        n_cmp++;
        if ({out_pc, out_instr} !== exp_pair) begin
          n_err++;
          $display("FAIL rand_head_%0d got pc=%h instr=%h want pc=%h instr=%h", i, out_pc, out_instr, exp_pair[41:32], exp_pair[31:0]);
        end
      end
      n_cmp++; if (count !== 3'(mdl_q.size())) begin n_err++; $display("FAIL rand_count_%0d got %0d want %0d", i, count, mdl_q.size()); end
      n_cmp++; if (fetch_en !== (mdl_q.size() != DEPTH)) begin n_err++; $display("FAIL rand_fetch_en_%0d got %b", i, fetch_en); end
      n_cmp++; if (ovf !== mdl_ovf) begin n_err++; $display("FAIL rand_ovf_%0d got %b want %b", i, ovf, mdl_ovf); end
      tick();
    end
  endtask

  initial begin
    mdl_ovf = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_flush();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
